// File: rtl/axi_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_pkg
// Purpose  : Shared constants and types for the AXI read-channel arbiter:
//            AXI ID / burst / size codes, FSM state encoding and the
//            requester index encoding used by arbiter and picker.
// Revision : 1.0 - initial release
// ============================================================================
package axi_rd_pkg;

    // AXI read IDs per requester
    localparam logic [3:0] ARID_ICACHE  = 4'd0;
    localparam logic [3:0] ARID_DCACHE  = 4'd1;
    localparam logic [3:0] ARID_UNCACHE = 4'd2;

    // Fixed AXI attributes
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    // Requester index; also the bit position in request/grant vectors
    localparam logic [1:0] REQ_ICACHE  = 2'd0;
    localparam logic [1:0] REQ_DCACHE  = 2'd1;
    localparam logic [1:0] REQ_UNCACHE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AR   = 2'd1,
        ST_R    = 2'd2,
        ST_DONE = 2'd3
    } rd_state_e;

    // One-hot grant to requester index (grant assumed one-hot or zero)
    function automatic logic [1:0] grant_to_idx(input logic [2:0] grant);
        if (grant[REQ_UNCACHE])     return REQ_UNCACHE;
        else if (grant[REQ_DCACHE]) return REQ_DCACHE;
        else                        return REQ_ICACHE;
    endfunction

    // Requester index to AXI read ID
    function automatic logic [3:0] idx_to_arid(input logic [1:0] idx);
        case (idx)
            REQ_DCACHE:  return ARID_DCACHE;
            REQ_UNCACHE: return ARID_UNCACHE;
            default:     return ARID_ICACHE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rd_arb_pick.sv
`default_nettype none
// ============================================================================
// Module   : rd_arb_pick
// Purpose  : Combinational requester picker. Three requests plus the index
//            of the last winner in, one-hot grant out.
//            RD_ARB_RR_EN defined  : round robin, the requester after the last
//                                    winner (icache->dcache->uncache->icache)
//                                    has highest priority.
//            RD_ARB_RR_EN undefined: fixed priority dcache > uncache > icache;
//                                    last_grant is ignored.
// Ports    : req[2:0]        - requests, bit = requester index
//            last_grant[1:0] - index of previous winner
//            grant[2:0]      - one-hot grant (zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module rd_arb_pick (
    input  logic [2:0] req,
    input  logic [1:0] last_grant,
    output logic [2:0] grant
);
    import axi_rd_pkg::*;

`ifdef RD_ARB_RR_EN
    function automatic logic [1:0] next_idx(input logic [1:0] p);
        return (p >= 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    logic [1:0] w_p0;
    logic [1:0] w_p1;
    logic [1:0] w_p2;

    assign w_p0 = next_idx(last_grant);
    assign w_p1 = next_idx(w_p0);
    assign w_p2 = next_idx(w_p1);

    always_comb begin
        grant = 3'b000;
        if (req[w_p0])      grant[w_p0] = 1'b1;
        else if (req[w_p1]) grant[w_p1] = 1'b1;
        else if (req[w_p2]) grant[w_p2] = 1'b1;
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^last_grant;

    always_comb begin
        grant = 3'b000;
        if (req[REQ_DCACHE])       grant[REQ_DCACHE]  = 1'b1;
        else if (req[REQ_UNCACHE]) grant[REQ_UNCACHE] = 1'b1;
        else if (req[REQ_ICACHE])  grant[REQ_ICACHE]  = 1'b1;
    end
`endif

endmodule
`default_nettype wire

// File: rtl/axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_rd_arbiter
// Purpose  : Shares one AXI read channel (AR/R) among icache refill, dcache
//            refill and uncached word reads. One transaction at a time;
//            burst beats are assembled into the winner's line register and
//            a one-cycle refresh pulse marks completion.
// Ports    : clk, resetn (async, active low)
//            icache_*/dcache_*/uncache_* : requester side (re, raddr in;
//                                          line/rdata, refresh out)
//            ar*/r*                      : AXI read address/data channels
//            rd_err                      : sticky protocol/response error
// Config   : RD_ARB_RR_EN - round-robin arbitration instead of fixed
//            dcache > uncache > icache priority.
// Revision : 1.0 - initial release
// ============================================================================
module axi_rd_arbiter #(
    parameter int CACHELINE_WD = 512,
    parameter int ADDR_WD      = 32
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    icache_re,
    input  logic [ADDR_WD-1:0]      icache_raddr,
    output logic [CACHELINE_WD-1:0] icache_cacheline_new,
    output logic                    icache_refresh,
    input  logic                    dcache_re,
    input  logic [ADDR_WD-1:0]      dcache_raddr,
    output logic [CACHELINE_WD-1:0] dcache_cacheline_new,
    output logic                    dcache_refresh,
    input  logic                    uncache_re,
    input  logic [ADDR_WD-1:0]      uncache_raddr,
    output logic [31:0]             uncache_rdata,
    output logic                    uncache_refresh,
    output logic [3:0]              arid,
    output logic [ADDR_WD-1:0]      araddr,
    output logic [3:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic                    rd_err
);
    import axi_rd_pkg::*;

    localparam int c_BEATS       = CACHELINE_WD / 32;
    localparam int c_OFFSET_BITS = $clog2(CACHELINE_WD / 8);
    localparam int c_IDX_WD      = $clog2(CACHELINE_WD);
    localparam logic [3:0] c_LAST_BEAT = 4'(c_BEATS - 1);
    localparam logic [ADDR_WD-1:0] c_LINE_MASK =
        {{(ADDR_WD - c_OFFSET_BITS){1'b1}}, {c_OFFSET_BITS{1'b0}}};

    rd_state_e             r_state;
    rd_state_e             w_next_state;
    logic [1:0]            r_req;
    logic [3:0]            r_beat;
    logic                  r_overrun;   // final beat seen without rlast
    logic [2:0]            w_req;
    logic [2:0]            w_grant;
    logic [1:0]            w_grant_idx;
    logic [1:0]            w_last_grant;
    logic [c_IDX_WD-1:0]   w_slice_lo;
    logic                  w_beat_err;

    assign w_req       = {uncache_re, dcache_re, icache_re};
    assign w_grant_idx = grant_to_idx(w_grant);
    assign w_slice_lo  = c_IDX_WD'({r_beat, 5'b00000});
    assign arsize      = AXI_SIZE_4B;
    assign arburst     = AXI_BURST_INCR;

    rd_arb_pick u_pick (
        .req        (w_req),
        .last_grant (w_last_grant),
        .grant      (w_grant)
    );

`ifdef RD_ARB_RR_EN
    // Resets to icache so the first rotation starts at dcache
    logic [1:0] r_last_grant;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_last_grant <= REQ_ICACHE;
        end else if (r_state == ST_IDLE && |w_req) begin
            r_last_grant <= w_grant_idx;
        end
    end

    assign w_last_grant = r_last_grant;
`else
    assign w_last_grant = REQ_ICACHE;
`endif

    // Any response fault on an accepted beat. A missing rlast is flagged
    // only once, on the beat that should have been last.
    assign w_beat_err = (rresp != 2'b00) || (rid != arid) ||
                        (rlast && (r_beat < arlen)) ||
                        (!rlast && !r_overrun && (r_beat == arlen));

    always_comb begin
        w_next_state    = r_state;
        arvalid         = 1'b0;
        rready          = 1'b0;
        icache_refresh  = 1'b0;
        dcache_refresh  = 1'b0;
        uncache_refresh = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|w_req) w_next_state = ST_AR;
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) w_next_state = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid && rlast) w_next_state = ST_DONE;
            end
            ST_DONE: begin
                icache_refresh  = (r_req == REQ_ICACHE);
                dcache_refresh  = (r_req == REQ_DCACHE);
                uncache_refresh = (r_req == REQ_UNCACHE);
                w_next_state    = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state              <= ST_IDLE;
            r_req                <= REQ_ICACHE;
            r_beat               <= 4'd0;
            r_overrun            <= 1'b0;
            arid                 <= 4'd0;
            araddr               <= '0;
            arlen                <= 4'd0;
            rd_err               <= 1'b0;
            icache_cacheline_new <= '0;
            dcache_cacheline_new <= '0;
            uncache_rdata        <= 32'd0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                ST_IDLE: begin
                    r_beat    <= 4'd0;
                    r_overrun <= 1'b0;
                    if (|w_req) begin
                        r_req <= w_grant_idx;
                        arid  <= idx_to_arid(w_grant_idx);
                        if (w_grant[REQ_UNCACHE]) begin
                            araddr <= uncache_raddr;
                            arlen  <= 4'd0;
                        end else if (w_grant[REQ_DCACHE]) begin
                            araddr <= dcache_raddr & c_LINE_MASK;
                            arlen  <= c_LAST_BEAT;
                        end else begin
                            araddr <= icache_raddr & c_LINE_MASK;
                            arlen  <= c_LAST_BEAT;
                        end
                    end
                end
                ST_R: begin
                    if (rvalid) begin
                        if (w_beat_err) rd_err <= 1'b1;
                        // Beats past the expected length are dropped
                        if (!r_overrun) begin
                            case (r_req)
                                REQ_UNCACHE: uncache_rdata <= rdata;
                                REQ_DCACHE:  dcache_cacheline_new[w_slice_lo +: 32] <= rdata;
                                default:     icache_cacheline_new[w_slice_lo +: 32] <= rdata;
                            endcase
                            if (r_beat == arlen) r_overrun <= 1'b1;
                            else                 r_beat    <= r_beat + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_rd_arbiter
// Purpose  : Self-checking bench for axi_rd_arbiter. Requests push the
//            expected AR fields and data seed into a queue; the AXI slave
//            model pops them when the DUT issues AR and checks address
//            phase, assembled data, refresh pulses and rd_err.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_rd_arbiter;
    localparam int LW = 512;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          icache_re = 1'b0;
    logic [31:0]   icache_raddr = 32'd0;
    logic [LW-1:0] icache_cacheline_new;
    logic          icache_refresh;
    logic          dcache_re = 1'b0;
    logic [31:0]   dcache_raddr = 32'd0;
    logic [LW-1:0] dcache_cacheline_new;
    logic          dcache_refresh;
    logic          uncache_re = 1'b0;
    logic [31:0]   uncache_raddr = 32'd0;
    logic [31:0]   uncache_rdata;
    logic          uncache_refresh;
    logic [3:0]    arid;
    logic [31:0]   araddr;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready = 1'b0;
    logic [3:0]    rid = 4'd0;
    logic [31:0]   rdata = 32'd0;
    logic [1:0]    rresp = 2'd0;
    logic          rlast = 1'b0;
    logic          rvalid = 1'b0;
    logic          rready;
    logic          rd_err;
    logic [2:0]    refresh_vec;

    assign refresh_vec = {uncache_refresh, dcache_refresh, icache_refresh};

    typedef struct {
        logic [3:0]  arid;
        logic [31:0] araddr;
        logic [3:0]  arlen;
        logic [31:0] seed;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_refresh_cyc = 0;
    int   last_g = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_rd_arbiter dut (
        .clk                  (clk),
        .resetn               (resetn),
        .icache_re            (icache_re),
        .icache_raddr         (icache_raddr),
        .icache_cacheline_new (icache_cacheline_new),
        .icache_refresh       (icache_refresh),
        .dcache_re            (dcache_re),
        .dcache_raddr         (dcache_raddr),
        .dcache_cacheline_new (dcache_cacheline_new),
        .dcache_refresh       (dcache_refresh),
        .uncache_re           (uncache_re),
        .uncache_raddr        (uncache_raddr),
        .uncache_rdata        (uncache_rdata),
        .uncache_refresh      (uncache_refresh),
        .arid                 (arid),
        .araddr               (araddr),
        .arlen                (arlen),
        .arsize               (arsize),
        .arburst              (arburst),
        .arvalid              (arvalid),
        .arready              (arready),
        .rid                  (rid),
        .rdata                (rdata),
        .rresp                (rresp),
        .rlast                (rlast),
        .rvalid               (rvalid),
        .rready               (rready),
        .rd_err               (rd_err)
    );

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        icache_re = 1'b0; dcache_re = 1'b0; uncache_re = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        last_g = 0;
    endtask

    // who: 0 icache, 1 dcache, 2 uncache
    task automatic request(input int who, input logic [31:0] addr, input logic [31:0] seed);
        exp_t e;
        e.arid = 4'(who);
        e.seed = seed;
        if (who == 2) begin
            e.araddr = addr;
            e.arlen  = 4'd0;
        end else begin
            e.araddr = {addr[31:6], 6'b000000};
            e.arlen  = 4'd15;
        end
        case (who)
            0: begin icache_re = 1'b1; icache_raddr = addr; end
            1: begin dcache_re = 1'b1; dcache_raddr = addr; end
            default: begin uncache_re = 1'b1; uncache_raddr = addr; end
        endcase
        exp_q.push_back(e);
    endtask

    // AXI slave for one transaction. bad_beat: beat carrying rresp=2'b10;
    // last_beat: beat carrying rlast (-1 = natural end); abort_beat: beat at
    // which resetn is pulled low instead of being driven.
    task automatic serve(input int ar_delay, input bit gaps, input int bad_beat,
                         input int last_beat, input int abort_beat, input bit chk_data);
        exp_t          e;
        int            n;
        int            k;
        int            lastb;
        logic [LW-1:0] el;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty: observed size 0 expected nonzero");
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        n = 0;
        while (arvalid !== 1'b1 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("arvalid", arvalid, 1'b1);
        if (arvalid !== 1'b1) return;
        chk("arid", arid, e.arid);
        chk("araddr", araddr, e.araddr);
        chk("arlen", arlen, e.arlen);
        chk("arsize", arsize, 3'b010);
        chk("arburst", arburst, 2'b01);
        for (int i = 0; i < ar_delay; i++) begin
            @(posedge clk); #1;
            chk("ar_hold_valid", arvalid, 1'b1);
            chk("ar_hold_addr", araddr, e.araddr);
        end
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        chk("rready", rready, 1'b1);
        lastb = (last_beat >= 0) ? last_beat : int'(e.arlen);
        k = 0;
        forever begin
            rvalid = 1'b1;
            rid    = e.arid;
            rdata  = e.seed + 32'(k);
            rresp  = (k == bad_beat) ? 2'b10 : 2'b00;
            rlast  = (k == lastb);
            if (k == abort_beat) begin
                resetn = 1'b0;
                rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
                icache_re = 1'b0; dcache_re = 1'b0; uncache_re = 1'b0;
                #1;
                chk("rst_refresh", refresh_vec, 3'b000);
                chk("rst_arvalid", arvalid, 1'b0);
                chk("rst_rready", rready, 1'b0);
                chk("rst_rd_err", rd_err, 1'b0);
                chk("rst_arid", arid, 4'd0);
                chk("rst_araddr", araddr, 32'd0);
                chk("rst_icache_line", icache_cacheline_new, '0);
                chk("rst_dcache_line", dcache_cacheline_new, '0);
                chk("rst_uncache_rdata", uncache_rdata, 32'd0);
                @(posedge clk); #1;
                resetn = 1'b1;
                last_g = 0;
                return;
            end
            @(posedge clk); #1;
            if (rlast) break;
            chk("no_early_refresh", refresh_vec, 3'b000);
            k++;
            if (gaps) begin
                rvalid = 1'b0;
                @(posedge clk); #1;
            end
        end
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        chk("refresh_onehot", refresh_vec, 3'b001 << e.arid);
        last_refresh_cyc = cyc;
        if (chk_data) begin
            el = '0;
            for (int j = 0; j <= int'(e.arlen); j++) el[32*j +: 32] = e.seed + 32'(j);
            case (e.arid)
                4'd0:    chk("icache_line", icache_cacheline_new, el);
                4'd1:    chk("dcache_line", dcache_cacheline_new, el);
                default: chk("uncache_rdata", uncache_rdata, e.seed);
            endcase
        end
        case (e.arid)
            4'd0:    icache_re = 1'b0;
            4'd1:    dcache_re = 1'b0;
            default: uncache_re = 1'b0;
        endcase
        last_g = int'(e.arid);
        @(posedge clk); #1;
        chk("refresh_pulse", refresh_vec, 3'b000);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ord[3];
        int n0;

        do_reset();
        chk("reset_arvalid", arvalid, 1'b0);
        chk("reset_rready", rready, 1'b0);
        chk("reset_refresh", refresh_vec, 3'b000);
        chk("reset_rd_err", rd_err, 1'b0);
        chk("reset_araddr", araddr, 32'd0);
        chk("reset_arlen", arlen, 4'd0);
        chk("reset_icache_line", icache_cacheline_new, '0);
        chk("reset_uncache_rdata", uncache_rdata, 32'd0);

        // Single icache refill, minimum latency, rdata = beat index
        request(0, 32'h1FC0_0024, 32'h0);
        n0 = cyc;
        serve(0, 1'b0, -1, -1, -1, 1'b1);
        chk("icache_latency", 32'(last_refresh_cyc - n0), 32'd18);

        // Uncached read with arready held off 3 cycles
        request(2, 32'hBFAF_8004, 32'hDEAD_BEEF);
        n0 = cyc;
        serve(3, 1'b0, -1, -1, -1, 1'b1);
        chk("uncache_latency", 32'(last_refresh_cyc - n0), 32'd6);

        // All three requesters at once, two rounds
        for (int r = 0; r < 2; r++) begin
`ifdef RD_ARB_RR_EN
            for (int i = 0; i < 3; i++) ord[i] = (last_g + 1 + i) % 3;
`else
            ord[0] = 1; ord[1] = 2; ord[2] = 0;
`endif
            for (int i = 0; i < 3; i++)
                request(ord[i], 32'h0040_001C + 32'(r * 3 + i) * 32'h1000,
                        32'h1000_0000 * 32'(i + 1) + 32'(r) * 32'h100);
            for (int i = 0; i < 3; i++) serve(0, 1'b0, -1, -1, -1, 1'b1);
        end

        // dcache burst with rvalid every other cycle
        request(1, 32'h8000_0FFF, 32'hA500_0000);
        serve(0, 1'b1, -1, -1, -1, 1'b1);
        chk("rd_err_clean", rd_err, 1'b0);

        // Error response on beat 5: data still captured, rd_err sticky
        request(1, 32'h0000_2040, 32'h5500_0000);
        serve(1, 1'b0, 5, -1, -1, 1'b1);
        chk("rd_err_rresp", rd_err, 1'b1);
        request(0, 32'h0000_3000, 32'h6600_0000);
        serve(0, 1'b0, -1, -1, -1, 1'b1);
        chk("rd_err_sticky", rd_err, 1'b1);

        // Separate run: early rlast on beat 10
        do_reset();
        chk("rd_err_after_reset", rd_err, 1'b0);
        request(1, 32'h0000_4080, 32'h7700_0000);
        serve(0, 1'b0, -1, 10, -1, 1'b0);
        chk("rd_err_early_last", rd_err, 1'b1);
        chk("idle_after_early_last", arvalid, 1'b0);
        request(1, 32'h0000_5000, 32'h8800_0000);
        serve(0, 1'b0, -1, -1, -1, 1'b1);
        chk("rd_err_sticky2", rd_err, 1'b1);

        // Reset mid-burst at beat 7, then a normal transaction
        request(1, 32'h0000_6000, 32'h9900_0000);
        serve(0, 1'b0, -1, -1, 7, 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_refresh_after_abort", refresh_vec, 3'b000);
        end
        request(0, 32'h0000_7004, 32'hAA00_0000);
        serve(0, 1'b0, -1, -1, -1, 1'b1);
        chk("rd_err_after_abort", rd_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
